// File: rtl/timed_settings_scheduler_pkg.sv
// Shared types and constants for the timed settings scheduler.
// The queue entry layout is {has_time, time, addr, data}, MSB first.
package timed_settings_scheduler_pkg;

  localparam int TIME_W = 64;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_EVAL  = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  function automatic int entry_width(input int awidth, input int dwidth);
    return 1 + TIME_W + awidth + dwidth;
  endfunction

endpackage

// File: rtl/tss_cmd_fifo.sv
// Command queue for the scheduler: show-ahead synchronous FIFO with registered
// occupancy, empty flag and write-ready (registered !full, held low in reset).
module tss_cmd_fifo #(
  parameter int FIFO_SIZE = 5,
  parameter int WIDTH     = 105
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 ready,
  output logic                 empty,
  output logic [FIFO_SIZE:0]   count
);

  localparam int DEPTH = 1 << FIFO_SIZE;
  localparam logic [FIFO_SIZE:0]   FULL_COUNT = (FIFO_SIZE+1)'(DEPTH);
  localparam logic [FIFO_SIZE:0]   CNT_ONE    = (FIFO_SIZE+1)'(1);
  localparam logic [FIFO_SIZE-1:0] PTR_ONE    = FIFO_SIZE'(1);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [FIFO_SIZE-1:0] wr_ptr;
  logic [FIFO_SIZE-1:0] rd_ptr;
  logic [FIFO_SIZE:0]   count_nxt;
  logic                 wr;
  logic                 rd;

  // A clear wins over both a write and a read in the same cycle.
  assign wr = wr_en && ready && !clear;
  assign rd = rd_en && !empty && !clear;

  always_comb begin
    count_nxt = count;
    if (clear)
      count_nxt = '0;
    else if (wr && !rd)
      count_nxt = count + CNT_ONE;
    else if (rd && !wr)
      count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      ready  <= 1'b0;
    end else begin
      count <= count_nxt;
      empty <= (count_nxt == '0);
      ready <= (count_nxt != FULL_COUNT);
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr) wr_ptr <= wr_ptr + PTR_ONE;
        if (rd) rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/timed_settings_scheduler.sv
// Queues settings-bus writes with optional VITA timestamps and releases them in
// order as single-cycle strobes once vita_time reaches each command's time.
module timed_settings_scheduler
  import timed_settings_scheduler_pkg::*;
#(
  parameter int FIFO_SIZE = 5,
  parameter int AWIDTH    = 8,
  parameter int DWIDTH    = 32,
  parameter int DROP_LATE = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [TIME_W-1:0] vita_time,
  input  logic              holdoff,
  input  logic              cmd_tvalid,
  output logic              cmd_tready,
  input  logic              cmd_has_time,
  input  logic [TIME_W-1:0] cmd_time,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_data,
  output logic              set_stb,
  output logic [AWIDTH-1:0] set_addr,
  output logic [DWIDTH-1:0] set_data,
  output logic              late_stb,
  output logic [AWIDTH-1:0] late_addr,
  output logic [FIFO_SIZE:0] occupancy
);

  localparam int ENTRY_W = entry_width(AWIDTH, DWIDTH);
  localparam logic [FIFO_SIZE:0] ONE_ENTRY = (FIFO_SIZE+1)'(1);

  state_t              state;
  state_t              state_nxt;
  logic                push;
  logic                pop;
  logic                issue;
  logic                late;
  logic                empty;
  logic [ENTRY_W-1:0]  head;
  logic                head_has_time;
  logic [TIME_W-1:0]   head_time;
  logic [AWIDTH-1:0]   head_addr;
  logic [DWIDTH-1:0]   head_data;

  assign push = cmd_tvalid && cmd_tready && !clear;

  tss_cmd_fifo #(
    .FIFO_SIZE (FIFO_SIZE),
    .WIDTH     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .wr_en   (push),
    .wr_data ({cmd_has_time, cmd_time, cmd_addr, cmd_data}),
    .rd_en   (pop),
    .rd_data (head),
    .ready   (cmd_tready),
    .empty   (empty),
    .count   (occupancy)
  );

  assign head_has_time = head[ENTRY_W-1];
  assign head_time     = head[AWIDTH+DWIDTH +: TIME_W];
  assign head_addr     = head[DWIDTH +: AWIDTH];
  assign head_data     = head[DWIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_EMPTY;
    else          state <= state_nxt;
  end

  // Lateness is only judged on first evaluation; a head already in WAIT is
  // issued normally even if vita_time jumps past its timestamp.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    late      = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_EMPTY: if (!empty) state_nxt = ST_EVAL;
      ST_EVAL: begin
        if (!holdoff) begin
          if (!head_has_time || vita_time == head_time) begin
            issue = 1'b1;
            pop   = 1'b1;
          end else if (vita_time > head_time) begin
            late  = 1'b1;
            issue = (DROP_LATE == 0);
            pop   = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!holdoff && vita_time >= head_time) begin
          issue = 1'b1;
          pop   = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (pop)
      state_nxt = (occupancy != ONE_ENTRY || push) ? ST_EVAL : ST_EMPTY;
    if (clear) begin
      state_nxt = ST_EMPTY;
      issue     = 1'b0;
      late      = 1'b0;
      pop       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      set_stb   <= 1'b0;
      set_addr  <= '0;
      set_data  <= '0;
      late_stb  <= 1'b0;
      late_addr <= '0;
    end else begin
      set_stb  <= issue;
      late_stb <= late;
      if (issue) begin
        set_addr <= head_addr;
        set_data <= head_data;
      end
      if (late) late_addr <= head_addr;
    end
  end

endmodule

// File: tb/tb_timed_settings_scheduler.sv
// Directed bench for timed_settings_scheduler: one DUT issues late commands,
// a second (DROP_LATE=1) drops them; expected values are hand-computed.
module tb_timed_settings_scheduler;

  localparam int FS = 5;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk          = 1'b0;
  logic          reset_n      = 1'b0;
  logic          clear        = 1'b0;
  logic          holdoff      = 1'b0;
  logic [63:0]   vita_time    = 64'd0;
  logic          cmd_tvalid   = 1'b0;
  logic          drop_tvalid  = 1'b0;
  logic          cmd_has_time = 1'b0;
  logic [63:0]   cmd_time     = 64'd0;
  logic [AW-1:0] cmd_addr     = '0;
  logic [DW-1:0] cmd_data     = '0;

  logic          cmd_tready, set_stb, late_stb;
  logic [AW-1:0] set_addr, late_addr;
  logic [DW-1:0] set_data;
  logic [FS:0]   occupancy;

  logic          d_tready, d_set_stb, d_late_stb;
  logic [AW-1:0] d_set_addr, d_late_addr;
  logic [DW-1:0] d_set_data;
  logic [FS:0]   d_occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  timed_settings_scheduler #(
    .FIFO_SIZE(FS), .AWIDTH(AW), .DWIDTH(DW), .DROP_LATE(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .vita_time(vita_time),
    .holdoff(holdoff), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
    .cmd_has_time(cmd_has_time), .cmd_time(cmd_time), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .late_stb(late_stb), .late_addr(late_addr),
    .occupancy(occupancy)
  );

  timed_settings_scheduler #(
    .FIFO_SIZE(FS), .AWIDTH(AW), .DWIDTH(DW), .DROP_LATE(1)
  ) dut_drop (
    .clk(clk), .reset_n(reset_n), .clear(clear), .vita_time(vita_time),
    .holdoff(holdoff), .cmd_tvalid(drop_tvalid), .cmd_tready(d_tready),
    .cmd_has_time(cmd_has_time), .cmd_time(cmd_time), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .set_stb(d_set_stb), .set_addr(d_set_addr),
    .set_data(d_set_data), .late_stb(d_late_stb), .late_addr(d_late_addr),
    .occupancy(d_occupancy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic valid, input logic has_time,
                                input logic [63:0] t, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data);
    cmd_tvalid   = valid;
    cmd_has_time = has_time;
    cmd_time     = t;
    cmd_addr     = addr;
    cmd_data     = data;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset state
    tick();
    check_output("rst_set_stb", set_stb, 0);
    check_output("rst_tready", cmd_tready, 0);
    check_output("rst_occ", occupancy, 0);
    reset_n = 1'b1;
    tick();
    check_output("rel_tready", cmd_tready, 1);
    check_output("rel_late_stb", late_stb, 0);

    // Untimed burst: strobes on three consecutive cycles, 2 clocks after accept
    apply_stimulus(1, 0, 0, 8'h10, 32'd1);
    tick();
    apply_stimulus(1, 0, 0, 8'h11, 32'd2);
    tick();
    check_output("burst_early", set_stb, 0);
    apply_stimulus(1, 0, 0, 8'h12, 32'd3);
    tick();
    apply_stimulus(0, 0, 0, 8'h00, 32'd0);
    check_output("burst0_stb", set_stb, 1);
    check_output("burst0_addr", set_addr, 8'h10);
    check_output("burst0_data", set_data, 1);
    check_output("burst0_late", late_stb, 0);
    tick();
    check_output("burst1_stb", set_stb, 1);
    check_output("burst1_addr", set_addr, 8'h11);
    check_output("burst1_data", set_data, 2);
    tick();
    check_output("burst2_stb", set_stb, 1);
    check_output("burst2_addr", set_addr, 8'h12);
    check_output("burst2_data", set_data, 3);
    check_output("burst2_occ", occupancy, 0);
    tick();
    check_output("burst_done", set_stb, 0);

    // Timed head blocks an untimed follower until vita_time hits 1010
    vita_time = 64'd1000;
    apply_stimulus(1, 1, 64'd1010, 8'h20, 32'h55);
    tick();
    apply_stimulus(1, 0, 0, 8'h21, 32'h66);
    tick();
    apply_stimulus(0, 0, 0, 8'h00, 32'd0);
    for (int v = 1001; v <= 1010; v++) begin
      vita_time = 64'(v);
      tick();
      if (v < 1010) check_output("wait_no_stb", set_stb, 0);
    end
    check_output("wait_stb", set_stb, 1);
    check_output("wait_addr", set_addr, 8'h20);
    check_output("wait_data", set_data, 32'h55);
    check_output("wait_late", late_stb, 0);
    vita_time = 64'd1011;
    tick();
    check_output("follow_stb", set_stb, 1);
    check_output("follow_addr", set_addr, 8'h21);
    tick();
    check_output("follow_done", set_stb, 0);
    check_output("follow_occ", occupancy, 0);

    // Late command: issued by the main DUT, dropped by the DROP_LATE DUT
    vita_time = 64'd500;
    apply_stimulus(1, 1, 64'd400, 8'h30, 32'h7);
    drop_tvalid = 1'b1;
    tick();
    apply_stimulus(0, 0, 0, 8'h00, 32'd0);
    drop_tvalid = 1'b0;
    tick();
    check_output("late_early", late_stb, 0);
    tick();
    check_output("late_stb", late_stb, 1);
    check_output("late_addr", late_addr, 8'h30);
    check_output("late_set_stb", set_stb, 1);
    check_output("late_set_addr", set_addr, 8'h30);
    check_output("drop_late_stb", d_late_stb, 1);
    check_output("drop_late_addr", d_late_addr, 8'h30);
    check_output("drop_set_stb", d_set_stb, 0);
    check_output("drop_occ", d_occupancy, 0);
    tick();
    check_output("late_pulse_end", late_stb, 0);

    // Fill the queue with far-future commands; 33rd is held by backpressure
    vita_time = 64'd600;
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(1, 1, 64'hFFFF_0000 + 64'(i), 8'(8'h40 + i), 32'(32'h100 + i));
      tick();
    end
    check_output("full_occ", occupancy, 32);
    check_output("full_tready", cmd_tready, 0);
    apply_stimulus(1, 0, 0, 8'h7F, 32'h33);
    tick();
    tick();
    check_output("held_occ", occupancy, 32);
    check_output("held_tready", cmd_tready, 0);
    check_output("held_stb", set_stb, 0);
    vita_time = 64'hFFFF_0000;
    tick();
    check_output("full_pop_stb", set_stb, 1);
    check_output("full_pop_addr", set_addr, 8'h40);
    check_output("full_pop_data", set_data, 32'h100);
    check_output("full_pop_occ", occupancy, 31);
    check_output("full_pop_tready", cmd_tready, 1);
    tick();
    apply_stimulus(0, 0, 0, 8'h00, 32'd0);
    check_output("accept33_occ", occupancy, 32);
    check_output("accept33_tready", cmd_tready, 0);
    check_output("accept33_stb", set_stb, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_output("flush_occ", occupancy, 0);
    check_output("flush_tready", cmd_tready, 1);

    // Holdoff delays an untimed command, then a timed one goes late under holdoff
    vita_time = 64'd2000;
    holdoff = 1'b1;
    apply_stimulus(1, 0, 0, 8'h50, 32'hAB);
    tick();
    apply_stimulus(0, 0, 0, 8'h00, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_output("holdoff_no_stb", set_stb, 0);
    end
    holdoff = 1'b0;
    tick();
    check_output("holdoff_stb", set_stb, 1);
    check_output("holdoff_addr", set_addr, 8'h50);
    tick();
    check_output("holdoff_done", set_stb, 0);
    holdoff = 1'b1;
    apply_stimulus(1, 1, 64'd2010, 8'h51, 32'hCD);
    tick();
    apply_stimulus(0, 0, 0, 8'h00, 32'd0);
    vita_time = 64'd2020;
    tick();
    tick();
    check_output("holdoff_no_late", late_stb, 0);
    holdoff = 1'b0;
    tick();
    check_output("holdoff_late_stb", late_stb, 1);
    check_output("holdoff_late_addr", late_addr, 8'h51);
    check_output("holdoff_late_set", set_stb, 1);
    tick();

    // Clear with a waiting head; the simultaneous write is discarded
    vita_time = 64'd3000;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, 1, 64'd4000 + 64'(i), 8'(8'h60 + i), 32'(i));
      tick();
    end
    apply_stimulus(0, 0, 0, 8'h00, 32'd0);
    tick();
    tick();
    check_output("pre_clear_occ", occupancy, 5);
    clear = 1'b1;
    apply_stimulus(1, 0, 0, 8'h6F, 32'hEE);
    tick();
    clear = 1'b0;
    apply_stimulus(0, 0, 0, 8'h00, 32'd0);
    check_output("clear_occ", occupancy, 0);
    vita_time = 64'd5000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output("post_clear_stb", set_stb, 0);
      check_output("post_clear_late", late_stb, 0);
    end

    // Async reset while the head waits
    apply_stimulus(1, 1, 64'd6000, 8'h70, 32'h9);
    tick();
    apply_stimulus(1, 0, 0, 8'h71, 32'hA);
    tick();
    apply_stimulus(0, 0, 0, 8'h00, 32'd0);
    tick();
    tick();
    check_output("pre_rst_occ", occupancy, 2);
    check_output("pre_rst_addr", set_addr, 8'h51);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("rst_now_addr", set_addr, 0);
    check_output("rst_now_late_addr", late_addr, 0);
    check_output("rst_now_occ", occupancy, 0);
    check_output("rst_now_tready", cmd_tready, 0);
    tick();
    reset_n = 1'b1;
    vita_time = 64'd7000;
    tick();
    check_output("rst_rel_tready", cmd_tready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("rst_no_stb", set_stb, 0);
      check_output("rst_no_late", late_stb, 0);
    end
    check_output("rst_final_occ", occupancy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
